// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared constants for the LED PWM driver
//
// Purpose: register addresses, CTRL bit positions, reset values and default
// widths used by led_pwm_driver and led_pwm_timebase.
// Ports: none (package).
package led_pwm_pkg;

    localparam int NUM_LEDS_DEF   = 10;
    localparam int PWM_BITS_DEF   = 8;
    localparam int PRESCALE_W_DEF = 16;

    // Register map
    localparam logic [1:0] ADDR_CTRL      = 2'd0;
    localparam logic [1:0] ADDR_DUTY      = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE  = 2'd2;
    localparam logic [1:0] ADDR_BLINK_DIV = 2'd3;

    // CTRL bit positions; CTRL_FADING is read-only status
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_FADING   = 2;

    // Reset values (DUTY and the duty shadow reset to all ones in the top)
    localparam logic [1:0] CTRL_RST        = 2'b00;
    localparam logic [7:0] BLINK_DIV_RST   = 8'd0;
    localparam logic       BLINK_PHASE_RST = 1'b1;

endpackage

// File: rtl/led_pwm_timebase.sv
// rtl/led_pwm_timebase.sv - prescaler and PWM counter for the LED PWM driver
//
// Purpose: divides clk by (prescale+1) into tick, counts ticks in pwm_cnt and
// pulses period_start for one cycle after each pwm_cnt wrap.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   enable           0 holds both counters at 0 and suppresses period_start
//   prescale         prescaler reload value (count runs 0..prescale)
//   prescale_clr     restarts the prescaler count (a PRESCALE write)
//   tick             combinational, high on the cycle the prescaler hits prescale
//   pwm_cnt          current PWM counter value
//   period_start     registered one-cycle pulse following the wrap edge
module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  prescale_clr,
    output logic                  tick,
    output logic [PWM_BITS-1:0]   pwm_cnt,
    output logic                  period_start
);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                  period_start_q, period_start_d;

    // Compare uses the current (pre-write) reload, so a PRESCALE write on a
    // tick cycle still lets that tick fire.
    assign tick         = enable && (pre_cnt_q == prescale);
    assign pwm_cnt      = pwm_cnt_q;
    assign period_start = period_start_q;

    always_comb begin
        pre_cnt_d      = pre_cnt_q;
        pwm_cnt_d      = pwm_cnt_q;
        period_start_d = 1'b0;
        if (!enable) begin
            pre_cnt_d = '0;
            pwm_cnt_d = '0;
        end else begin
            if (prescale_clr || tick) begin
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
            end
            if (tick) begin
                pwm_cnt_d      = pwm_cnt_q + PWM_BITS'(1);
                period_start_d = (pwm_cnt_q == '1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - global PWM brightness and blink gate for the LED PIO word
//
// Purpose: Avalon-MM configured PWM/blink gating of led_in onto led_out.
// Optional feature macro: LED_PWM_FADE_EN (duty shadow steps by one toward
// DUTY each period; CTRL bit2 reports fading in progress).
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata, readdata                  register slave, zero-wait reads
//   led_in                               LED word from the PIO
//   led_out                              registered LED pin drive
//   period_start                         one-cycle pulse per PWM period
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS   = NUM_LEDS_DEF,
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_start
);

    logic [1:0]            ctrl_q, ctrl_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [7:0]            blink_div_q, blink_div_d;
    logic [PWM_BITS-1:0]   duty_sh_q, duty_sh_d;
    logic [7:0]            blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_LEDS-1:0]   led_out_q, led_out_d;

    logic                  wr_en;
    logic                  enable;
    logic                  blink_en;
    logic                  tick;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  wrap;
    logic                  pwm_on;
    logic                  gate;
    logic                  fading;

    assign wr_en    = chipselect && !write_n;
    assign enable   = ctrl_q[CTRL_ENABLE];
    assign blink_en = ctrl_q[CTRL_BLINK_EN];

    led_pwm_timebase #(
        .PWM_BITS   (PWM_BITS),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .prescale     (prescale_q),
        .prescale_clr (wr_en && (address == ADDR_PRESCALE)),
        .tick         (tick),
        .pwm_cnt      (pwm_cnt),
        .period_start (period_start)
    );

    // Same edge on which the timebase wraps and raises period_start.
    assign wrap = tick && (pwm_cnt == '1);

    assign pwm_on = (duty_sh_q == '1) ? 1'b1 : (pwm_cnt < duty_sh_q);
    assign gate   = blink_en ? blink_phase_q : 1'b1;

`ifdef LED_PWM_FADE_EN
    assign fading = (duty_sh_q != duty_q);
`else
    assign fading = 1'b0;
`endif

    // Register file
    always_comb begin
        ctrl_d      = ctrl_q;
        duty_d      = duty_q;
        prescale_d  = prescale_q;
        blink_div_d = blink_div_q;
        if (wr_en) begin
            case (address)
                ADDR_CTRL:      ctrl_d      = writedata[1:0];
                ADDR_DUTY:      duty_d      = writedata[PWM_BITS-1:0];
                ADDR_PRESCALE:  prescale_d  = writedata[PRESCALE_W-1:0];
                default:        blink_div_d = writedata[7:0];
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[1:0]         = ctrl_q;
                readdata[CTRL_FADING] = fading;
            end
            ADDR_DUTY:     readdata[PWM_BITS-1:0]   = duty_q;
            ADDR_PRESCALE: readdata[PRESCALE_W-1:0] = prescale_q;
            default:       readdata[7:0]            = blink_div_q;
        endcase
    end

    // Duty shadow: only changes on the wrap edge, so a period never sees a
    // mid-period DUTY write. While disabled it is preloaded so the first
    // enabled cycle already compares against the right value.
    always_comb begin
        duty_sh_d = duty_sh_q;
`ifdef LED_PWM_FADE_EN
        if (!enable) begin
            duty_sh_d = '0;
        end else if (wrap) begin
            if (duty_sh_q < duty_q) begin
                duty_sh_d = duty_sh_q + PWM_BITS'(1);
            end else if (duty_sh_q > duty_q) begin
                duty_sh_d = duty_sh_q - PWM_BITS'(1);
            end
        end
`else
        if (!enable || wrap) begin
            duty_sh_d = duty_q;
        end
`endif
    end

    // Blink divider advances once per PWM period
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!enable) begin
            blink_cnt_d   = '0;
            blink_phase_d = BLINK_PHASE_RST;
        end else if (wrap) begin
            if (blink_cnt_q == blink_div_q) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        led_out_d = '0;
        if (enable) begin
            led_out_d = led_in & {NUM_LEDS{pwm_on & gate}};
        end
    end

    assign led_out = led_out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= CTRL_RST;
            duty_q        <= '1;
            prescale_q    <= '0;
            blink_div_q   <= BLINK_DIV_RST;
            duty_sh_q     <= '1;
            blink_cnt_q   <= '0;
            blink_phase_q <= BLINK_PHASE_RST;
            led_out_q     <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            duty_q        <= duty_d;
            prescale_q    <= prescale_d;
            blink_div_q   <= blink_div_d;
            duty_sh_q     <= duty_sh_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_out_q     <= led_out_d;
        end
    end

endmodule
